fpu_norm_round: RTL
===================

# fpu_norm_round

Multi-cycle normalize/round/pack stage directly downstream of the FPU result selector. Captures the selected raw result (sign, 9-bit biased exponent, 49-bit fixed-point mantissa) when `done_cal` is high. Normalizes by iterative 1-bit shifts, rounds to nearest-even, and packs an IEEE-754 single-precision word with status flags for the FPU writeback path.

## Interface
Parameters:
- `EXP_W`, 9: raw exponent width.
- `MAN_W`, 49: raw mantissa width.
- `FRAC_W`, 23: packed fraction width.

Ports (clock is `clk`, one clock domain; reset is `rst`, asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `done_cal`  in  1  selector result valid; sampled only in IDLE
- `result_sign_in`  in  1  raw sign
- `result_exp_in`  in  9  raw biased exponent (bias 127), unsigned
- `result_man_in`  in  49  raw mantissa; bit48 = 2^1, bit47 = 2^0, bits46:0 fraction
- `busy`  out  1  high in any state other than IDLE
- `result_valid`  out  1  one-cycle pulse when outputs update
- `fp_result`  out  32  packed single-precision result; held until next update
- `flag_overflow`  out  1  held with `fp_result`
- `flag_underflow`  out  1  held with `fp_result`
- `flag_inexact`  out  1  held with `fp_result`

## Operation
- States are IDLE, NORM and ROUND.
  - IDLE→NORM on a clock edge with `done_cal`=1. At that edge, capture sign, exp (zero-extended to 10-bit `exp_i`), man into `man_r`, and clear `sticky`.
- NORM evaluates one case per cycle, in this priority:
  1. `man_r`==0: go to ROUND with the zero flag set.
  2. `man_r[48]`: shift right 1, OR the shifted-out bit into `sticky`, `exp_i`+1, go to ROUND.
  3. `man_r[47]`: go to ROUND.
  4. `exp_i`≤1: go to ROUND with the flush flag set.
  5. Otherwise: shift left 1, `exp_i`−1, stay in NORM.
- ROUND runs for one cycle, then returns to IDLE and registers the outputs.
  - Zero: `fp_result` = {sign, 31'b0}; no flags.
  - Flush, or `exp_i`==0: `fp_result` = {sign, 31'b0}; underflow=1, inexact=1.
  - Otherwise apply RNE with keep = `man_r[47:24]`, G = `man_r[23]`, S = `|man_r[22:0] | sticky`.
    - Increment keep when G & (S | keep[0]).
    - Carry out of keep: keep = 24'h800000 and `exp_i`+1.
    - inexact = G | S.
  - After rounding, if `exp_i`≥255: `fp_result` = {sign, 8'hFF, 23'b0}; overflow=1, inexact=1.
  - Else `fp_result` = {sign, `exp_i[7:0]`, keep[22:0]}.
- `done_cal` while busy is ignored; no queueing.
- `exp_i` is 10 bits, so increments never wrap.

## Timing
- Reset values: state IDLE; `busy`=0; `result_valid`=0; `fp_result`=0; all flags 0; internal registers 0.
- Latency from the accepting edge to `result_valid` high is 2+N cycles, where N is the number of NORM cycles.
  - Already-normalized, right-shift, zero and exp-flush inputs: N=1, latency 3.
  - k left shifts: N=k+1, latency k+3. Maximum is 47 shifts, latency 50.
- `result_valid` is high exactly one cycle, the first cycle back in IDLE. A new `done_cal` may be accepted at the edge ending that cycle, so throughput is one result per latency.
- `rst` in any state aborts immediately: back to IDLE, outputs return to reset values, and the in-flight result is discarded with no `result_valid`.

## Structure
- Shared package `fpu_pkg` holds:
  - state enum `norm_state_t` (IDLE, NORM, ROUND);
  - constants EXP_BIAS=127, EXP_INF=255, QNAN_INF word 32'h7F800000;
  - width constants EXP_W, MAN_W, FRAC_W.
- One natural sub-module, `fpu_round_rne`: combinational; takes keep/G/S and outputs rounded keep, carry and inexact.

## Test plan
- exp=127, man=1<<47, sign=0 → `fp_result`=0x3F800000 at latency 3; all flags 0.
- exp=127, man=bits48|47 (3.0) → 0x40400000 at latency 3. Then exp=137, man=1<<37, sign=1 → 0xBF800000 at latency 13.
- RNE cases:
  - exp=127, man=(1<<47)|(1<<23) → 0x3F800000, inexact=1 (tie, even).
  - man=bits47:23 all ones → 0x40000000, inexact=1 (carry).
- exp=300, man=1<<47 → 0x7F800000, overflow=1, inexact=1. Then exp=3, man=1<<40 → 0x00000000, underflow=1, inexact=1, latency 5.
- man=0, sign=1 → 0x80000000, no flags, latency 3. A second `done_cal` pulse while busy → no extra `result_valid`.
- `rst` pulsed mid-NORM during a 20-shift operation → `busy`=0 and `fp_result`=0 immediately, no `result_valid`. The next request then completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normalize/round state encoding, IEEE-754 single constants
// and the raw result widths used by the selector and the writeback stage.
package fpu_pkg;

  localparam int EXP_W  = 9;
  localparam int MAN_W  = 49;
  localparam int FRAC_W = 23;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_INF  = 255;
  localparam logic [31:0] QNAN_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND
  } norm_state_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even on a (FRAC_W+1)-bit significand using guard and sticky bits.
// A carry out renormalizes the significand to 1.0; the caller bumps the exponent.
module fpu_round_rne #(
  parameter int FRAC_W = fpu_pkg::FRAC_W
) (
  input  logic [FRAC_W:0] keep,
  input  logic            g,
  input  logic            s,
  output logic [FRAC_W:0] keep_rnd,
  output logic            carry,
  output logic            inexact
);

  logic              inc;
  logic [FRAC_W+1:0] sum;

  always_comb begin
    inc      = g & (s | keep[0]);
    sum      = {1'b0, keep} + {{(FRAC_W + 1){1'b0}}, inc};
    carry    = sum[FRAC_W+1];
    keep_rnd = carry ? {1'b1, {FRAC_W{1'b0}}} : sum[FRAC_W:0];
    inexact  = g | s;
  end

endmodule

// File: rtl/fpu_norm_round.sv
// Normalize/round/pack stage behind the FPU result selector: one-bit-per-cycle
// normalization, RNE rounding and IEEE-754 single packing with status flags.
module fpu_norm_round #(
  parameter int EXP_W  = fpu_pkg::EXP_W,
  parameter int MAN_W  = fpu_pkg::MAN_W,
  parameter int FRAC_W = fpu_pkg::FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_cal,
  input  logic             result_sign_in,
  input  logic [EXP_W-1:0] result_exp_in,
  input  logic [MAN_W-1:0] result_man_in,
  output logic             busy,
  output logic             result_valid,
  output logic [31:0]      fp_result,
  output logic             flag_overflow,
  output logic             flag_underflow,
  output logic             flag_inexact
);

  import fpu_pkg::*;

  localparam int KEEP_LO = MAN_W - 2 - FRAC_W;
  localparam int PE      = 31 - FRAC_W;
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W + 1)'(1);
  localparam logic [EXP_W:0] EXP_TOP = (EXP_W + 1)'(EXP_INF);

  norm_state_t      state, state_nx;
  logic             sign_r, sign_nx;
  logic [EXP_W:0]   exp_i, exp_nx;
  logic [MAN_W-1:0] man_r, man_nx;
  logic             sticky, sticky_nx;
  logic             zero_r, zero_nx;
  logic             flush_r, flush_nx;

  logic [31:0] fp_nx;
  logic        ov_nx, uf_nx, ix_nx, valid_nx;

  logic [FRAC_W:0] keep_rnd;
  logic            rnd_carry, rnd_inexact;
  logic [EXP_W:0]  exp_rnd;
  logic [PE-1:0]   exp_field;

  fpu_round_rne #(.FRAC_W(FRAC_W)) u_round (
    .keep     (man_r[MAN_W-2:KEEP_LO]),
    .g        (man_r[KEEP_LO-1]),
    .s        ((|man_r[KEEP_LO-2:0]) | sticky),
    .keep_rnd (keep_rnd),
    .carry    (rnd_carry),
    .inexact  (rnd_inexact)
  );

  assign busy    = (state != IDLE);
  assign exp_rnd = exp_i + {{EXP_W{1'b0}}, rnd_carry};
  // A significand without its hidden bit packs with a zero exponent field.
  assign exp_field = keep_rnd[FRAC_W] ? exp_rnd[PE-1:0] : '0;

  always_comb begin
    state_nx  = state;
    sign_nx   = sign_r;
    exp_nx    = exp_i;
    man_nx    = man_r;
    sticky_nx = sticky;
    zero_nx   = zero_r;
    flush_nx  = flush_r;
    fp_nx     = fp_result;
    ov_nx     = flag_overflow;
    uf_nx     = flag_underflow;
    ix_nx     = flag_inexact;
    valid_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (done_cal) begin
          state_nx  = NORM;
          sign_nx   = result_sign_in;
          exp_nx    = {1'b0, result_exp_in};
          man_nx    = result_man_in;
          sticky_nx = 1'b0;
          zero_nx   = 1'b0;
          flush_nx  = 1'b0;
        end
      end
      NORM: begin
        if (man_r == '0) begin
          zero_nx  = 1'b1;
          state_nx = ROUND;
        end else if (man_r[MAN_W-1]) begin
          man_nx    = man_r >> 1;
          sticky_nx = sticky | man_r[0];
          exp_nx    = exp_i + EXP_ONE;
          state_nx  = ROUND;
        end else if (man_r[MAN_W-2]) begin
          state_nx = ROUND;
        end else if (exp_i <= EXP_ONE) begin
          flush_nx = 1'b1;
          state_nx = ROUND;
        end else begin
          man_nx = man_r << 1;
          exp_nx = exp_i - EXP_ONE;
        end
      end
      ROUND: begin
        state_nx = IDLE;
        valid_nx = 1'b1;
        ov_nx    = 1'b0;
        uf_nx    = 1'b0;
        ix_nx    = 1'b0;
        if (zero_r) begin
          fp_nx = {sign_r, 31'b0};
        end else if (flush_r || exp_i == '0) begin
          fp_nx = {sign_r, 31'b0};
          uf_nx = 1'b1;
          ix_nx = 1'b1;
        end else if (exp_rnd >= EXP_TOP) begin
          fp_nx = QNAN_INF | {sign_r, 31'b0};
          ov_nx = 1'b1;
          ix_nx = 1'b1;
        end else begin
          fp_nx = {sign_r, exp_field, keep_rnd[FRAC_W-1:0]};
          ix_nx = rnd_inexact;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      sign_r         <= 1'b0;
      exp_i          <= '0;
      man_r          <= '0;
      sticky         <= 1'b0;
      zero_r         <= 1'b0;
      flush_r        <= 1'b0;
      fp_result      <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
      result_valid   <= 1'b0;
    end else begin
      state          <= state_nx;
      sign_r         <= sign_nx;
      exp_i          <= exp_nx;
      man_r          <= man_nx;
      sticky         <= sticky_nx;
      zero_r         <= zero_nx;
      flush_r        <= flush_nx;
      fp_result      <= fp_nx;
      flag_overflow  <= ov_nx;
      flag_underflow <= uf_nx;
      flag_inexact   <= ix_nx;
      result_valid   <= valid_nx;
    end
  end

endmodule
